// File: rtl/gray_cnt_sched_if.sv
// Scheduler bus: requester levels and pause in, grant/owner and Gray count out.
interface gray_cnt_sched_if #(
    parameter int CBITS = 18,
    parameter int NREQ  = 4
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]  req;
    logic             pause;
    logic [NREQ-1:0]  gnt;
    logic [OW-1:0]    owner;
    logic [CBITS-1:0] gray_cnt;
    logic             cnt_valid;
    logic             sig;

    // Requester side drives requests and pause, observes the schedule.
    modport master (
        output req, pause,
        input  gnt, owner, gray_cnt, cnt_valid, sig
    );

    // Scheduler side.
    modport slave (
        input  req, pause,
        output gnt, owner, gray_cnt, cnt_valid, sig
    );
endinterface

// File: rtl/gray_cnt_sched.sv
// Round-robin scheduler sharing one Gray-code counter between NREQ requesters.
// The owner advances the counter once per unpaused cycle for at most MAXBURST
// counts; each grant is preceded by exactly one arbitration (IDLE) cycle.
module gray_cnt_sched #(
    parameter int CBITS    = 18,
    parameter int NREQ     = 4,
    parameter int MAXBURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    gray_cnt_sched_if.slave   bus
);
    localparam int OW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BCW = $clog2(MAXBURST + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [CBITS-1:0] b_q, b_d;
    logic [OW-1:0]    ptr_q, ptr_d;
    logic [BCW-1:0]   bc_q, bc_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic             valid_q, valid_d;
    logic             sig_q, sig_d;

    logic [OW-1:0]    pick;
    logic             found;
    logic [CBITS-1:0] b_inc;
    logic [BCW-1:0]   bc_inc;
    logic [OW-1:0]    ptr_next;

    function automatic logic [CBITS-1:0] to_gray(input logic [CBITS-1:0] b);
        return b ^ (b >> 1);
    endfunction

    assign b_inc    = b_q + CBITS'(1);
    assign bc_inc   = bc_q + BCW'(1);
    assign ptr_next = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + OW'(1);

    // Circular search for the first active request starting at ptr.
    always_comb begin
        int unsigned idx;
        idx   = 0;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(ptr_q) + i) % NREQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = OW'(idx);
            end
        end
    end

    // Next-state and output decode for the IDLE/BUSY scheduler.
    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        ptr_d   = ptr_q;
        bc_d    = bc_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        valid_d = 1'b0;
        sig_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    owner_d     = pick;
                    bc_d        = '0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (!bus.req[owner_q]) begin
                    // Owner drop takes priority over pause.
                    gnt_d   = '0;
                    ptr_d   = ptr_next;
                    state_d = IDLE;
                end else if (!bus.pause) begin
                    b_d     = b_inc;
                    valid_d = 1'b1;
                    sig_d   = (to_gray(b_inc) == '0);
                    bc_d    = bc_inc;
                    if (bc_inc == BCW'(MAXBURST)) begin
                        gnt_d   = '0;
                        ptr_d   = ptr_next;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            b_q     <= '0;
            ptr_q   <= '0;
            bc_q    <= '0;
            gnt_q   <= '0;
            owner_q <= '0;
            valid_q <= 1'b0;
            sig_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            ptr_q   <= ptr_d;
            bc_q    <= bc_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            valid_q <= valid_d;
            sig_q   <= sig_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.owner     = owner_q;
    assign bus.gray_cnt  = to_gray(b_q);
    assign bus.cnt_valid = valid_q;
    assign bus.sig       = sig_q;
endmodule
